fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  Fetch-side consumer of the execute/writeback redirect signals (BranchTakenE, PCSrcW).
//  Owns the fetch PC and issues instruction-memory requests.
//  Applies branch/PC-write redirects and drives the D/E pipeline flushes.
//  Keeps a pending redirect safe while an instruction-memory access is outstanding.
// PARAMETERS
//  WIDTH     32  PC / address / target width
//  RESET_PC  0   PCF value after reset
//  PC_INC    4   sequential PC increment (bytes)
//  CNT_W     8   width of saturating redirect counter
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  StallF         in   1      hazard-unit fetch stall
//  BranchTakenE   in   1      taken branch resolved in execute
//  BranchTargetE  in   WIDTH  branch target from execute
//  PCSrcW         in   1      instruction in writeback writes PC
//  ResultW        in   WIDTH  new PC value for PCSrcW
//  ImemReady      in   1      imem completes current access this cycle
//  PCF            out  WIDTH  current fetch address (registered)
//  ImemReq        out  1      fetch request to imem
//  FetchValidF    out  1      fetched instruction this cycle is valid for decode
//  FlushD         out  1      flush decode register
//  FlushE         out  1      flush execute register
//  RedirectCount  out  CNT_W  number of redirect cycles, saturating
// BEHAVIOUR
//  - Reset (rst=1 at edge): PCF=RESET_PC, state=IDLE, pend cleared, RedirectCount=0.
//    While rst=1, ImemReq/FetchValidF/FlushD/FlushE are forced to 0. Reset mid-DRAIN abandons the pending target.
//  - redir = PCSrcW | BranchTakenE; target = PCSrcW ? ResultW : BranchTargetE (PCSrcW has priority).
//  - FlushD = FlushE = redir & ~rst (combinational, same cycle as redir, in every state).
//  - States:
//    IDLE:  one cycle after reset; ImemReq=0, FetchValidF=0; redir ignored; next RUN.
//    RUN:   ImemReq=1.
//           redir & ImemReady   -> PCF<=target, stay RUN, FetchValidF=0.
//           redir & ~ImemReady  -> pend<=target, DRAIN, FetchValidF=0.
//           ~redir & ~ImemReady -> PCF held, WAIT, FetchValidF=0.
//           ~redir & ImemReady & StallF  -> PCF held, FetchValidF=0.
//           ~redir & ImemReady & ~StallF -> PCF<=PCF+PC_INC, FetchValidF=1.
//    WAIT:  ImemReq=1; same transitions as RUN (the wait is the outstanding access).
//    DRAIN: ImemReq=1, FetchValidF=0 (response discarded).
//           redir   -> pend<=target (latest redirect wins).
//           ImemReady -> PCF <= (redir ? target : pend), next RUN.
//  - A redirect always overrides StallF; a redirect is never dropped.
//  - PC arithmetic wraps modulo 2^WIDTH (0xFFFFFFFC+4 -> 0x00000000).
//  - RedirectCount increments on each cycle with redir=1 outside IDLE and saturates at 2^CNT_W-1.
//  - Latency: redirect asserted at cycle t with ImemReady=1 -> PCF=target at t+1.
// TESTING
//  1. Reset then ImemReady=1, no stall: PCF 0 (IDLE), 0, 4, 8, 12; FetchValidF 0,1,1,1.
//  2. BranchTakenE=1, BranchTargetE=0x100 at PCF=0x8: FlushD=FlushE=1 that cycle; PCF=0x100 next, FetchValidF=0.
//  3. Same cycle PCSrcW=1 (ResultW=0x200) and BranchTakenE=1 (0x100) -> PCF=0x200, RedirectCount+1.
//  4. ImemReady=0 and BranchTakenE to 0x40 -> DRAIN, PCF held.
//     Next cycle PCSrcW to 0x80 -> pend=0x80.
//     ImemReady=1 -> FetchValidF=0, PCF=0x80.
//  5. StallF=1 with BranchTakenE to 0x300 -> PCF=0x300 despite stall.
//     StallF=1 alone -> PCF held, FetchValidF=0.
//  6. Wrap and saturation: PCF=0xFFFFFFFC advances to 0. 300 redirect cycles -> RedirectCount=255.
//     rst during DRAIN -> PCF=0, state IDLE, no pending redirect applied.

Source files
------------

// File: rtl/fetch_redirect_unit_if.sv
// Fetch redirect bus: hazard/redirect inputs, imem handshake and fetch outputs.
// The slave side is the fetch unit; the master side drives redirects and imem.
interface fetch_redirect_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             StallF;
  logic             BranchTakenE;
  logic [WIDTH-1:0] BranchTargetE;
  logic             PCSrcW;
  logic [WIDTH-1:0] ResultW;
  logic             ImemReady;
  logic [WIDTH-1:0] PCF;
  logic             ImemReq;
  logic             FetchValidF;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] RedirectCount;

  modport master (
    output StallF, BranchTakenE, BranchTargetE,
    output PCSrcW, ResultW, ImemReady,
    input  PCF, ImemReq, FetchValidF,
    input  FlushD, FlushE, RedirectCount
  );

  modport slave (
    input  StallF, BranchTakenE, BranchTargetE,
    input  PCSrcW, ResultW, ImemReady,
    output PCF, ImemReq, FetchValidF,
    output FlushD, FlushE, RedirectCount
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: applies execute/writeback redirects, flushes D/E,
// and parks a redirect while an imem access is still outstanding.
module fetch_redirect_unit #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4,
  parameter int              CNT_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DRAIN
  } state_e;

  localparam logic [WIDTH-1:0] Inc = WIDTH'(PC_INC);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             redir;
  logic [WIDTH-1:0] target;
  logic             req;
  logic             fvalid;
  logic             rdy;

  assign redir  = bus.PCSrcW | bus.BranchTakenE;
  assign target = bus.PCSrcW ? bus.ResultW
                             : bus.BranchTargetE;
  assign rdy    = bus.ImemReady;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    req     = 1'b0;
    fvalid  = 1'b0;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN, WAIT: begin
        req = 1'b1;
        unique case (1'b1)
          redir & rdy: begin
            pc_d    = target;
            state_d = RUN;
          end
          redir & ~rdy: begin
            pend_d  = target;
            state_d = DRAIN;
          end
          ~redir & ~rdy: state_d = WAIT;
          ~redir & rdy & bus.StallF: state_d = RUN;
          ~redir & rdy & ~bus.StallF: begin
            pc_d    = pc_q + Inc;
            fvalid  = 1'b1;
            state_d = RUN;
          end
          default: state_d = state_q;
        endcase
      end
      DRAIN: begin
        req = 1'b1;
        if (redir) pend_d = target;
        // The drained response is dropped; the newest redirect wins.
        if (rdy) begin
          pc_d    = redir ? target : pend_q;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redir && state_q != IDLE && cnt_q != CntMax)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCF           = pc_q;
  assign bus.ImemReq       = req & ~rst;
  assign bus.FetchValidF   = fvalid & ~rst;
  assign bus.FlushD        = redir & ~rst;
  assign bus.FlushE        = redir & ~rst;
  assign bus.RedirectCount = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: sequential fetch, redirects,
// drain of outstanding access, stall override, wrap, saturation, reset.
module tb_fetch_redirect_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_redirect_unit_if #(.WIDTH(32), .CNT_W(8)) bus ();

  fetch_redirect_unit #(
    .WIDTH(32), .RESET_PC(32'h0), .PC_INC(4), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic bt, logic [31:0] bta,
                       logic ps, logic [31:0] res,
                       logic rdy, logic st);
    bus.BranchTakenE  = bt;
    bus.BranchTargetE = bta;
    bus.PCSrcW        = ps;
    bus.ResultW       = res;
    bus.ImemReady     = rdy;
    bus.StallF        = st;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_pc", bus.PCF, 32'h0);
    chk("rst_req", {31'b0, bus.ImemReq}, 32'h0);
    chk("rst_flushd", {31'b0, bus.FlushD}, 32'h0);
    chk("rst_flushe", {31'b0, bus.FlushE}, 32'h0);
    chk("rst_cnt", {24'b0, bus.RedirectCount}, 32'h0);

    // 1: sequential fetch
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("idle_pc", bus.PCF, 32'h0);
    chk("idle_req", {31'b0, bus.ImemReq}, 32'h0);
    chk("idle_fv", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    chk("run0_pc", bus.PCF, 32'h0);
    chk("run0_req", {31'b0, bus.ImemReq}, 32'h1);
    chk("run0_fv", {31'b0, bus.FetchValidF}, 32'h1);
    tick();
    chk("run1_pc", bus.PCF, 32'h4);
    chk("run1_fv", {31'b0, bus.FetchValidF}, 32'h1);
    tick();
    chk("run2_pc", bus.PCF, 32'h8);

    // 2: branch at PCF=8
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("br_flushd", {31'b0, bus.FlushD}, 32'h1);
    chk("br_flushe", {31'b0, bus.FlushE}, 32'h1);
    chk("br_fv", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("br_pc", bus.PCF, 32'h100);
    chk("br_cnt", {24'b0, bus.RedirectCount}, 32'h1);

    // 3: PCSrcW beats BranchTakenE
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("prio_pc", bus.PCF, 32'h200);
    chk("prio_cnt", {24'b0, bus.RedirectCount}, 32'h2);

    // 4: redirect while access outstanding
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("dr_fv0", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("dr_pc_held", bus.PCF, 32'h200);
    chk("dr_req", {31'b0, bus.ImemReq}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("dr_pc_held2", bus.PCF, 32'h200);
    chk("dr_fv_done", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    chk("dr_pc", bus.PCF, 32'h80);
    chk("dr_cnt", {24'b0, bus.RedirectCount}, 32'h4);
    chk("dr_run_fv", {31'b0, bus.FetchValidF}, 32'h1);

    // 5: redirect overrides stall, then stall alone
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("st_br_fv", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("st_br_pc", bus.PCF, 32'h300);
    chk("st_fv", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    chk("st_pc_held", bus.PCF, 32'h300);

    // wait state: access not ready, then completes
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wt_fv0", {31'b0, bus.FetchValidF}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wt_pc_held", bus.PCF, 32'h300);
    chk("wt_req", {31'b0, bus.ImemReq}, 32'h1);
    chk("wt_fv1", {31'b0, bus.FetchValidF}, 32'h1);
    tick();
    chk("wt_pc_adv", bus.PCF, 32'h304);

    // 6: wrap
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wr_pc", bus.PCF, 32'hFFFF_FFFC);
    chk("wr_cnt", {24'b0, bus.RedirectCount}, 32'h6);
    tick();
    chk("wr_pc0", bus.PCF, 32'h0);

    // saturation: 300 consecutive redirect cycles
    drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("sat_cnt", {24'b0, bus.RedirectCount}, 32'hFF);
    chk("sat_pc", bus.PCF, 32'h10);

    // reset in DRAIN drops the pending target
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rd_req_rst", {31'b0, bus.ImemReq}, 32'h0);
    chk("rd_flush_rst", {31'b0, bus.FlushD}, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rd_pc", bus.PCF, 32'h0);
    chk("rd_idle_req", {31'b0, bus.ImemReq}, 32'h0);
    chk("rd_cnt", {24'b0, bus.RedirectCount}, 32'h0);
    tick();
    chk("rd_run_pc", bus.PCF, 32'h0);
    chk("rd_run_fv", {31'b0, bus.FetchValidF}, 32'h1);
    tick();
    chk("rd_run_pc4", bus.PCF, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
